fwd_hazard_ctrl: RTL and testbench

- Control-side counterpart of the pipeline's 3:1 operand multiplexers.
- Tracks destination registers of in-flight instructions in an internal shadow pipeline (ID/EX, EX/MEM, MEM/WB).
- Drives the 2-bit select for the EX-stage operand A/B muxes; detects load-use hazards, requesting a one-cycle stall plus bubble.
- Sits beside the ID and EX stages of the 5-stage CPU; gated by the debug unit's step/run enable.

---
 rtl/cpu_ctrl_pkg.sv | 36 +++
 rtl/fwd_src_sel.sv | 49 ++++
 rtl/fwd_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared definitions for the pipeline control blocks:
//     - register address width and forwarding select width
//     - forwarding select encoding (matches the EX operand mux data order)
//     - shadow-stage records used to track in-flight destination registers
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int NB_REG = 5;
    localparam int NB_SEL = 2;

    // Operand mux select encoding; 2'b11 is never driven.
    localparam logic [NB_SEL-1:0] FWD_REGFILE = 2'b00;
    localparam logic [NB_SEL-1:0] FWD_MEMWB   = 2'b01;
    localparam logic [NB_SEL-1:0] FWD_EXMEM   = 2'b10;

    // ID/EX shadow record: enough to drive forwarding for the EX operands
    // and to spot a load whose result the next instruction needs.
    typedef struct packed {
        logic              valid;
        logic [NB_REG-1:0] rs;
        logic [NB_REG-1:0] rt;
        logic [NB_REG-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } idex_t;

    // EX/MEM and MEM/WB shadow record: only the producer side matters here.
    typedef struct packed {
        logic              valid;
        logic [NB_REG-1:0] rd;
        logic              reg_write;
    } exwb_t;

endpackage

// File: rtl/fwd_src_sel.sv
// -----------------------------------------------------------------------------
// fwd_src_sel
//   Forwarding source select for one EX-stage operand. Purely combinational
//   priority compare: the EX/MEM producer (youngest) wins over MEM/WB, and
//   register 0 is never forwarded.
//
// Ports:
//   src              source register of the EX instruction for this operand
//   exmem_valid      EX/MEM holds a real instruction
//   exmem_reg_write  EX/MEM instruction writes the register file
//   exmem_rd         EX/MEM destination register
//   memwb_valid      MEM/WB holds a real instruction
//   memwb_reg_write  MEM/WB instruction writes the register file
//   memwb_rd         MEM/WB destination register
//   sel              operand mux select (FWD_REGFILE / FWD_MEMWB / FWD_EXMEM)
// -----------------------------------------------------------------------------
module fwd_src_sel
    import cpu_ctrl_pkg::*;
#(
    parameter int NB_REG = cpu_ctrl_pkg::NB_REG
) (
    input  logic [NB_REG-1:0] src,
    input  logic              exmem_valid,
    input  logic              exmem_reg_write,
    input  logic [NB_REG-1:0] exmem_rd,
    input  logic              memwb_valid,
    input  logic              memwb_reg_write,
    input  logic [NB_REG-1:0] memwb_rd,
    output logic [NB_SEL-1:0] sel
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_valid && exmem_reg_write
                       && (exmem_rd != '0) && (exmem_rd == src);
    assign memwb_hit = memwb_valid && memwb_reg_write
                       && (memwb_rd != '0) && (memwb_rd == src);

    always_comb begin
        sel = FWD_REGFILE;
        if (exmem_hit) begin
            sel = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Control side of the EX-stage 3:1 operand muxes. Keeps a shadow copy of
//   the ID/EX, EX/MEM and MEM/WB destination info, drives the operand A/B
//   forward selects and detects load-use hazards (one-cycle stall + bubble).
//   All shadow state advances only when the debug unit's enable is high.
//
// Build option:
//   FWD_STATS_EN  when defined, o_stall_count / o_fwd_count are live
//                 wrapping counters; otherwise they are tied to 0 and no
//                 counter flops exist.
//
// Ports:
//   i_clk           system clock
//   i_rst           synchronous reset, active-high (wins over i_en)
//   i_en            pipeline advance enable; state frozen when 0
//   i_id_valid      ID stage holds a real instruction
//   i_id_rs         ID source register 1
//   i_id_rt         ID source register 2
//   i_id_rd         ID destination register (already rt/rd-resolved)
//   i_id_reg_write  ID instruction writes the register file
//   i_id_mem_read   ID instruction is a load
//   o_fwd_a         operand A mux select for the EX instruction
//   o_fwd_b         operand B mux select for the EX instruction
//   o_stall         hold PC and IF/ID this cycle
//   o_bubble        zero ID/EX control this cycle
//   o_stall_count   total enabled stall cycles
//   o_fwd_count     total enabled cycles with any non-zero forward select
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int NB_REG = cpu_ctrl_pkg::NB_REG,
    parameter int NB_SEL = cpu_ctrl_pkg::NB_SEL,
    parameter int NB_CNT = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_id_valid,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    input  logic [NB_REG-1:0] i_id_rd,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    output logic [NB_SEL-1:0] o_fwd_a,
    output logic [NB_SEL-1:0] o_fwd_b,
    output logic              o_stall,
    output logic              o_bubble,
    output logic [NB_CNT-1:0] o_stall_count,
    output logic [NB_CNT-1:0] o_fwd_count
);

    idex_t idex;
    exwb_t exmem;
    exwb_t memwb;

    logic              stall;
    logic [NB_SEL-1:0] fwd_a;
    logic [NB_SEL-1:0] fwd_b;

    // Load-use: the load in EX has not produced data yet, so a dependent
    // instruction in ID must wait one cycle; it then picks the value up
    // from MEM/WB when it reaches EX.
    assign stall = i_id_valid && idex.valid && idex.mem_read
                   && (idex.rd != '0)
                   && ((idex.rd == i_id_rs) || (idex.rd == i_id_rt));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else if (i_en) begin
            memwb <= exmem;
            exmem <= '{valid:     idex.valid,
                       rd:        idex.rd,
                       reg_write: idex.reg_write};
            if (stall || !i_id_valid) begin
                idex <= '0;
            end else begin
                idex <= '{valid:     1'b1,
                          rs:        i_id_rs,
                          rt:        i_id_rt,
                          rd:        i_id_rd,
                          reg_write: i_id_reg_write,
                          mem_read:  i_id_mem_read};
            end
        end
    end

    fwd_src_sel #(.NB_REG(NB_REG)) u_sel_a (
        .src             (idex.rs),
        .exmem_valid     (exmem.valid),
        .exmem_reg_write (exmem.reg_write),
        .exmem_rd        (exmem.rd),
        .memwb_valid     (memwb.valid),
        .memwb_reg_write (memwb.reg_write),
        .memwb_rd        (memwb.rd),
        .sel             (fwd_a)
    );

    fwd_src_sel #(.NB_REG(NB_REG)) u_sel_b (
        .src             (idex.rt),
        .exmem_valid     (exmem.valid),
        .exmem_reg_write (exmem.reg_write),
        .exmem_rd        (exmem.rd),
        .memwb_valid     (memwb.valid),
        .memwb_reg_write (memwb.reg_write),
        .memwb_rd        (memwb.rd),
        .sel             (fwd_b)
    );

    assign o_fwd_a  = fwd_a;
    assign o_fwd_b  = fwd_b;
    assign o_stall  = stall;
    assign o_bubble = stall;

`ifdef FWD_STATS_EN
    logic [NB_CNT-1:0] stall_cnt;
    logic [NB_CNT-1:0] fwd_cnt;

    // Counters wrap naturally at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (i_en) begin
            if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((fwd_a != FWD_REGFILE) || (fwd_b != FWD_REGFILE)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end

    assign o_stall_count = stall_cnt;
    assign o_fwd_count   = fwd_cnt;
`else
    assign o_stall_count = '0;
    assign o_fwd_count   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//   Directed scenarios for forwarding, load-use, r0, enable freeze and reset,
//   then a randomized run against a history-based reference model: the model
//   keeps the list of instructions that entered EX, and looks up producers by
//   age (1 = EX/MEM, 2 = MEM/WB).
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

`ifdef FWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_rw;
    logic        id_mr;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall;
    logic        bubble;
    logic [31:0] stall_count;
    logic [31:0] fwd_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_id_valid     (id_valid),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_rd        (id_rd),
        .i_id_reg_write (id_rw),
        .i_id_mem_read  (id_mr),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b),
        .o_stall        (stall),
        .o_bubble       (bubble),
        .o_stall_count  (stall_count),
        .o_fwd_count    (fwd_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit       valid;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } instr_t;

    instr_t      hist[$];    // instructions that entered EX, newest last
    int unsigned m_stall_cnt;
    int unsigned m_fwd_cnt;

    function automatic instr_t at_age(int k);
        instr_t b = '{default: 0};
        if (hist.size() > k) return hist[hist.size() - 1 - k];
        return b;
    endfunction

    function automatic logic [1:0] model_sel(bit [4:0] src);
        instr_t p;
        for (int k = 1; k <= 2; k++) begin
            p = at_age(k);
            if (p.valid && p.rw && p.rd != 0 && p.rd == src)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit model_stall();
        instr_t e = at_age(0);
        return id_valid && e.valid && e.mr && e.rd != 0
               && (e.rd == id_rs || e.rd == id_rt);
    endfunction

    // One clock edge; model updated from the values present at the edge.
    task automatic tick();
        bit         st;
        logic [1:0] fa;
        logic [1:0] fb;
        instr_t     ni;
        st = model_stall();
        fa = model_sel(at_age(0).rs);
        fb = model_sel(at_age(0).rt);
        ni = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd, rw: id_rw, mr: id_mr};
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
        end else if (en) begin
            if (st) m_stall_cnt++;
            if (fa != 0 || fb != 0) m_fwd_cnt++;
            if (!id_valid || st) ni = '{default: 0};
            hist.push_back(ni);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    endtask

    task automatic set_id(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit rw, bit mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rw = rw; id_mr = mr;
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b1;
        set_id(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            #2;
            n_checks++;
            if ({fwd_a, fwd_b, stall, bubble} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %b expected 000000", i, {fwd_a, fwd_b, stall, bubble});
            end
            tick();
        end
        #2;
        n_checks++;
        if ({stall_count, fwd_count} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, fwd_count);
        end
    endtask

    task automatic test_fwd_paths();
        // add r3 ; sub rs=3 rt=4  -> A from EX/MEM
        apply_reset();
        set_id(1, 1, 2, 3, 1, 0); tick();
        set_id(1, 3, 4, 5, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0); #2;
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin
            n_fail++;
            $display("FAIL fwd_exmem: got a=%b b=%b expected a=10 b=00", fwd_a, fwd_b);
        end
        // add r3 ; nop ; and rs=5 rt=3 -> B from MEM/WB
        apply_reset();
        set_id(1, 1, 2, 3, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0); tick();
        set_id(1, 5, 3, 6, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0); #2;
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0001) begin
            n_fail++;
            $display("FAIL fwd_memwb: got a=%b b=%b expected a=00 b=01", fwd_a, fwd_b);
        end
        // add r3 ; add r3 ; or rs=3 -> youngest producer wins
        apply_reset();
        set_id(1, 1, 2, 3, 1, 0); tick();
        set_id(1, 0, 0, 3, 1, 0); tick();
        set_id(1, 3, 6, 7, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0); #2;
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin
            n_fail++;
            $display("FAIL fwd_priority: got a=%b b=%b expected a=10 b=00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_id(1, 1, 0, 7, 1, 1); tick();          // lw r7 now in EX
        set_id(1, 7, 2, 8, 1, 0); #2;              // add rs=7 in ID
        n_checks++;
        if ({stall, bubble} !== 2'b11) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b expected 11", {stall, bubble});
        end
        tick();                                    // consumer held in ID
        #2;
        n_checks++;
        if ({fwd_a, fwd_b, stall, bubble} !== 6'b0) begin
            n_fail++;
            $display("FAIL load_use_bubble: got %b expected 000000", {fwd_a, fwd_b, stall, bubble});
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0); #2;
        n_checks++;
        if ({fwd_a, fwd_b, stall} !== 5'b01000) begin
            n_fail++;
            $display("FAIL load_use_fwd: got %b expected 01000", {fwd_a, fwd_b, stall});
        end
    endtask

    task automatic test_r0();
        apply_reset();
        set_id(1, 1, 2, 0, 1, 0); tick();          // add r0
        set_id(1, 0, 0, 9, 1, 0); #2;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_alu_stall: got %b expected 0", stall);
        end
        tick();
        set_id(1, 1, 2, 0, 1, 1); #2;              // lw r0 next
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            n_fail++;
            $display("FAIL r0_alu_fwd: got a=%b b=%b expected 00 00", fwd_a, fwd_b);
        end
        tick();
        set_id(1, 0, 0, 9, 1, 0); #2;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_load_stall: got %b expected 0", stall);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0); #2;
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            n_fail++;
            $display("FAIL r0_load_fwd: got a=%b b=%b expected 00 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_enable_hold();
        apply_reset();
        set_id(1, 1, 0, 7, 1, 1); tick();
        set_id(1, 2, 7, 8, 1, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_checks++;
            if ({stall, bubble} !== 2'b11) begin
                n_fail++;
                $display("FAIL en_hold_stall cyc%0d: got %b expected 11", i, {stall, bubble});
            end
            tick();
        end
        en = 1'b1; #2;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL en_resume_stall: got %b expected 1", stall);
        end
        tick(); #2;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL en_resolve: got %b expected 0", stall);
        end
        n_checks++;
        if (stall_count !== (STATS ? 32'd1 : 32'd0)) begin
            n_fail++;
            $display("FAIL en_stall_count: got %0d expected %0d", stall_count, STATS ? 1 : 0);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0); #2;
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0001) begin
            n_fail++;
            $display("FAIL en_fwd: got a=%b b=%b expected 00 01", fwd_a, fwd_b);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        set_id(1, 1, 0, 7, 1, 1); tick();
        set_id(1, 7, 7, 8, 1, 0); #2;              // both operands hit
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stall_pre: got %b expected 1", stall);
        end
        rst = 1'b1; tick(); rst = 1'b0; #2;
        n_checks++;
        if ({fwd_a, fwd_b, stall, bubble, stall_count, fwd_count} !== 70'd0) begin
            n_fail++;
            $display("FAIL rst_stall_post: got a=%b b=%b st=%b bu=%b sc=%0d fc=%0d expected all 0",
                     fwd_a, fwd_b, stall, bubble, stall_count, fwd_count);
        end
    endtask

    task automatic test_random();
        int unsigned exp_sc;
        int unsigned exp_fc;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            en  = ($urandom_range(0, 99) < 80);
            set_id($urandom_range(0, 9) != 0,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0));
            #2;
            n_checks++;
            if ({fwd_a, fwd_b, stall, bubble} !==
                {model_sel(at_age(0).rs), model_sel(at_age(0).rt), model_stall(), model_stall()}) begin
                n_fail++;
                $display("FAIL rand_outputs cyc%0d: got %b expected %b", i, {fwd_a, fwd_b, stall, bubble},
                         {model_sel(at_age(0).rs), model_sel(at_age(0).rt), model_stall(), model_stall()});
            end
            exp_sc = STATS ? m_stall_cnt : 0;
            exp_fc = STATS ? m_fwd_cnt : 0;
            n_checks++;
            if (stall_count !== exp_sc || fwd_count !== exp_fc) begin
                n_fail++;
                $display("FAIL rand_counters cyc%0d: got %0d/%0d expected %0d/%0d",
                         i, stall_count, fwd_count, exp_sc, exp_fc);
            end
            tick();
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
        test_reset();
        test_fwd_paths();
        test_load_use();
        test_r0();
        test_enable_hold();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
